// File: rtl/stack_controller.sv
// Stack sequencer: owns the stack pointer and drives a dual-port memory.
// Serves PUSH/POP/TOP/CLEAR over a 4-phase req/ack handshake.
module stack_controller #(
   parameter int N           = 1024,
   parameter int M           = 32,
   parameter int IND_SIZE    = $clog2(N),
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req,
   input  logic [1:0]          op,
   input  logic [M-1:0]        data_in,
   output logic                ack,
   output logic [M-1:0]        data_out,
   output logic                err,
   output logic                empty,
   output logic                full,
   output logic [IND_SIZE-1:0] mem_ind1,
   output logic [IND_SIZE-1:0] mem_ind2,
   output logic [M-1:0]        mem_in,
   output logic                mem_beta,
   input  logic [M-1:0]        mem_out2
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_TOP   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [IND_SIZE:0]   SP_ONE   = 1;
   localparam logic [IND_SIZE:0]   SP_FULL  = (IND_SIZE+1)'(N);
   localparam logic [IND_SIZE-1:0] IND_ONE  = 1;
   localparam logic [CW-1:0]       CNT_ONE  = 1;
   localparam logic [CW-1:0]       CNT_INIT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   state_t            next;
   logic [IND_SIZE:0] sp;
   logic [CW-1:0]     counter;
   logic [1:0]        op_q;
   logic              reject;

   assign empty    = (sp == '0);
   assign full     = (sp == SP_FULL);
   assign mem_ind2 = sp[IND_SIZE-1:0] - IND_ONE;

   // A request that cannot be served from the current fill level.
   assign reject = ((op == OP_PUSH) && full) ||
                   (((op == OP_POP) || (op == OP_TOP)) && empty);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= next;
   end

   // Next-state selection.
   always_comb begin
      next = state;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               if (reject || (op == OP_CLEAR)) next = S_DONE;
               else if (op == OP_PUSH)         next = S_WRITE;
               else                            next = S_WAIT;
            end
         end
         S_WRITE: next = S_DONE;
         S_WAIT:  if (counter == '0) next = S_DONE;
         S_DONE:  if (!req) next = S_IDLE;
         default: next = S_IDLE;
      endcase
   end

   // Stack pointer, memory port drive and handshake outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         sp       <= '0;
         counter  <= '0;
         op_q     <= OP_PUSH;
         ack      <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
         mem_beta <= 1'b0;
         mem_ind1 <= '0;
         mem_in   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  op_q <= op;
                  if (reject) begin
                     err <= 1'b1;
                     ack <= 1'b1;
                  end else begin
                     err <= 1'b0;
                     unique case (op)
                        OP_PUSH: begin
                           mem_ind1 <= sp[IND_SIZE-1:0];
                           mem_in   <= data_in;
                           mem_beta <= 1'b1;
                        end
                        OP_POP, OP_TOP: counter <= CNT_INIT;
                        OP_CLEAR: begin
                           sp  <= '0;
                           ack <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_WRITE: begin
               mem_beta <= 1'b0;
               sp       <= sp + SP_ONE;
               ack      <= 1'b1;
            end
            S_WAIT: begin
               if (counter == '0) begin
                  data_out <= mem_out2;
                  if (op_q == OP_POP) sp <= sp - SP_ONE;
                  ack <= 1'b1;
               end else begin
                  counter <= counter - CNT_ONE;
               end
            end
            S_DONE: if (!req) ack <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller (N=4, M=8, WAIT_CYCLES=2).
// Behavioural dual-port memory writes on negedge, reads combinationally.
module tb_stack_controller;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_TOP   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req   = 1'b0;
   logic [1:0] op    = OP_PUSH;
   logic [7:0] data_in = '0;
   logic       ack;
   logic [7:0] data_out;
   logic       err;
   logic       empty;
   logic       full;
   logic [1:0] mem_ind1;
   logic [1:0] mem_ind2;
   logic [7:0] mem_in;
   logic       mem_beta;
   logic [7:0] mem_out2;
   logic [7:0] mem [4];

   int n_cmp = 0;
   int n_bad = 0;

   stack_controller #(
      .N(4), .M(8), .WAIT_CYCLES(2)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .op(op),
      .data_in(data_in), .ack(ack), .data_out(data_out),
      .err(err), .empty(empty), .full(full),
      .mem_ind1(mem_ind1), .mem_ind2(mem_ind2), .mem_in(mem_in),
      .mem_beta(mem_beta), .mem_out2(mem_out2)
   );

   always #5 clock = ~clock;

   // Memory model: write port on negedge, combinational read port.
   always @(negedge clock) if (mem_beta) mem[mem_ind1] <= mem_in;
   assign mem_out2 = mem[mem_ind2];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full 4-phase transaction; checks latency, err, write-enable pulses.
   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [7:0] d, input int exp_lat,
                        input logic exp_err, input int exp_beta);
      int lat;
      int beta;
      lat  = 0;
      beta = 0;
      req = 1'b1;
      op = o;
      data_in = d;
      while (lat < 20) begin
         tick();
         lat++;
         if (mem_beta) beta++;
         if (ack) break;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_beta"}, beta, exp_beta);
      req = 1'b0;
      op = 2'bxx;
      data_in = 8'hxx;
      tick();
      check({tag, "_ackfall"}, ack, 0);
   endtask

   initial begin
      int hold_ack;
      int hold_beta;
      reset = 1'b1;
      repeat (2) tick();
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_dout", data_out, 0);
      check("rst_beta", mem_beta, 0);
      check("rst_ind1", mem_ind1, 0);
      check("rst_min", mem_in, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ind2", mem_ind2, 3);
      reset = 1'b0;

      do_op("push11", OP_PUSH, 8'h11, 2, 0, 1);
      do_op("push22", OP_PUSH, 8'h22, 2, 0, 1);
      check("mem0", mem[0], 8'h11);
      check("mem1", mem[1], 8'h22);
      check("sp2_ind2", mem_ind2, 1);
      check("sp2_empty", empty, 0);

      do_op("top", OP_TOP, 8'h00, 3, 0, 0);
      check("top_dout", data_out, 8'h22);
      check("top_ind2", mem_ind2, 1);
      do_op("pop1", OP_POP, 8'h00, 3, 0, 0);
      check("pop1_dout", data_out, 8'h22);
      check("pop1_ind2", mem_ind2, 0);
      do_op("pop2", OP_POP, 8'h00, 3, 0, 0);
      check("pop2_dout", data_out, 8'h11);
      check("pop2_empty", empty, 1);

      do_op("pop_empty", OP_POP, 8'h00, 1, 1, 0);
      check("pope_dout", data_out, 8'h11);
      check("pope_empty", empty, 1);

      for (int i = 0; i < 4; i++)
         do_op("fill", OP_PUSH, 8'hA0 + 8'(i), 2, 0, 1);
      check("fill_full", full, 1);
      check("fill_mem3", mem[3], 8'hA3);
      do_op("push_full", OP_PUSH, 8'hFF, 1, 1, 0);
      check("pf_mem3", mem[3], 8'hA3);
      check("pf_full", full, 1);
      do_op("clear", OP_CLEAR, 8'h00, 1, 0, 0);
      check("clr_empty", empty, 1);
      check("clr_full", full, 0);
      check("clr_dout", data_out, 8'h11);

      req = 1'b1;
      op = OP_PUSH;
      data_in = 8'h55;
      tick();
      check("rw_beta_on", mem_beta, 1);
      reset = 1'b1;
      req = 1'b0;
      tick();
      check("rw_beta_off", mem_beta, 0);
      check("rw_ack", ack, 0);
      check("rw_empty", empty, 1);
      check("rw_ind2", mem_ind2, 3);
      reset = 1'b0;
      do_op("rw_pop", OP_POP, 8'h00, 1, 1, 0);

      req = 1'b1;
      op = OP_PUSH;
      data_in = 8'h77;
      repeat (2) tick();
      check("hold_ack_on", ack, 1);
      hold_ack = 0;
      hold_beta = 0;
      op = OP_POP;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ack) hold_ack++;
         if (mem_beta) hold_beta++;
      end
      check("hold_ack_cnt", hold_ack, 5);
      check("hold_beta", hold_beta, 0);
      check("hold_ind2", mem_ind2, 0);
      req = 1'b0;
      tick();
      check("hold_ackfall", ack, 0);
      do_op("b2b", OP_PUSH, 8'h88, 2, 0, 1);
      check("b2b_ind2", mem_ind2, 1);
      check("b2b_mem1", mem[1], 8'h88);

      req = 1'b1;
      op = OP_POP;
      tick();
      req = 1'b0;
      tick();
      tick();
      check("viol_ack", ack, 1);
      check("viol_dout", data_out, 8'h88);
      tick();
      check("viol_ackfall", ack, 0);
      check("viol_ind2", mem_ind2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Sequencer for the stack unit: owns the stack pointer and drives the dual-port memory (one read/write port, one read port).
- Serves PUSH / POP / TOP / CLEAR requests from one requester over a 4-phase req/ack handshake.
- Uses the read/write port for writes and the read-only port to address the current top.
- Inserts a programmable wait so memory access delay is covered before data is sampled.

Parameters:
- N, 1024, number of memory words (stack depth).
- M, 32, word width in bits.
- IND_SIZE, $clog2(N), memory address width.
- WAIT_CYCLES, 2, clock cycles between a stable read address and sampling of mem_out2. Must cover the memory access delay; minimum value 1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request from requester (4-phase).
- op  in  2  operation code: 00 PUSH, 01 POP, 10 TOP, 11 CLEAR.
- data_in  in  M  value to push.
- ack  out  1  operation complete; held while req=1.
- data_out  out  M  popped or top value; registered.
- err  out  1  operation rejected (PUSH when full, POP/TOP when empty); valid while ack=1.
- empty  out  1  sp==0.
- full  out  1  sp==N.
- mem_ind1  out  IND_SIZE  read/write port address.
- mem_ind2  out  IND_SIZE  read port address.
- mem_in  out  M  write data to memory.
- mem_beta  out  1  write enable; memory writes on negedge clock while high.
- mem_out2  in  M  read port data from memory.

Behaviour:
- Stack pointer sp: IND_SIZE+1 bits, range 0..N; points at the next free slot.
- Combinational outputs:
  - mem_ind2 = (sp-1) truncated to IND_SIZE; wraps to N-1 when sp=0, which is never sampled.
  - empty and full are derived combinationally from sp.
- Reset (synchronous, any state, including mid-operation):
  - sp=0, state IDLE, ack=0, err=0, data_out=0, mem_beta=0, mem_ind1=0, mem_in=0.
  - A write in progress is abandoned: mem_beta drops at the same posedge.
- States: IDLE, WRITE, WAIT, DONE.
- IDLE: on posedge with req=1, latch op and data_in, then:
  - PUSH && full, or (POP or TOP) && empty: err<=1, go to DONE. No memory access, sp unchanged.
  - PUSH: mem_ind1<=sp[IND_SIZE-1:0], mem_in<=data_in, mem_beta<=1, go to WRITE.
  - POP or TOP: counter<=WAIT_CYCLES-1, go to WAIT.
  - CLEAR: sp<=0, go to DONE. Memory contents are not erased.
  - All accepted operations set err<=0.
- WRITE: lasts exactly one cycle. mem_beta, mem_ind1 and mem_in are stable for the whole cycle, so the negedge write lands mid-cycle. At the next posedge: mem_beta<=0, sp<=sp+1, go to DONE.
- WAIT:
  - Decrement counter each cycle.
  - When counter==0: data_out<=mem_out2; for POP also sp<=sp-1; go to DONE.
  - mem_ind2 is stable throughout WAIT because sp changes only on leaving WRITE/WAIT or on CLEAR.
- DONE:
  - ack=1 (registered, asserted on DONE entry).
  - Stays in DONE while req=1.
  - When req=0 is sampled: ack<=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after ack falls.
- Latency, counted from the posedge sampling req=1 to ack=1:
  - PUSH: 2 cycles.
  - POP/TOP: WAIT_CYCLES+1 cycles.
  - CLEAR/error: 1 cycle.
- Protocol violation, req dropped before ack: the operation still completes fully. ack pulses for one cycle, then the block returns to IDLE.
- op and data_in are ignored outside IDLE.
- data_out holds its last value on PUSH, CLEAR and error.
- mem_beta is never asserted outside WRITE.

Test Plan (N=4, M=8, WAIT_CYCLES=2):
- Reset, then PUSH 0x11, 0x22 with full handshakes: each ack 2 cycles after req; mem_beta high exactly 1 cycle each; mem[0]=0x11, mem[1]=0x22; sp=2.
- TOP, then POP, POP: TOP returns 0x22 with sp still 2. POPs return 0x22 then 0x11, each ack 3 cycles after req. After that empty=1, err=0.
- POP on empty: ack after 1 cycle, err=1, data_out unchanged (0x11), sp=0, mem_beta never asserted.
- PUSH 0xA0..0xA3: full=1. A fifth PUSH 0xFF gives err=1, mem_beta stays 0, mem[3]=0xA3. CLEAR gives sp=0, empty=1, full=0, err=0.
- Assert reset during the WRITE cycle of PUSH 0x55: on the next posedge mem_beta=0, ack=0, sp=0, state IDLE. A subsequent POP returns err=1.
- Hold req=1 for 5 cycles after ack: ack stays 1 and no second operation starts. Drop req: ack falls next cycle. A back-to-back PUSH is then accepted and sp increments exactly once.
